// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and constants for the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receiver frame-tracking states; encoding fixed so debug captures stay stable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity mode selectors
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_deserializer_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sync2
//  Description : Two-flop synchroniser for an asynchronous, idle-high line.
//                Resets to 1 so a freshly reset receiver sees an idle line.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deserializer
//  Description : Parametrised UART receive front end. Oversamples rx on
//                baud_tick, validates the start bit, samples each bit at its
//                mid-point, checks optional parity and 1/2 stop bits, and
//                hands frames over through a valid/ready holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);

    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);

    // Synchronised serial line
    logic w_rx_s;

    // Frame tracking state
    rx_state_t            r_state,        w_state_nxt;
    logic [c_TW-1:0]      r_tick_cnt,     w_tick_cnt_nxt;
    logic [c_BW-1:0]      r_bit_cnt,      w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shreg,        w_shreg_nxt;
    logic                 r_cur_par_err,  w_cur_par_err_nxt;
    logic                 r_cur_frm_err,  w_cur_frm_err_nxt;

    // Line must be seen high after enable before a start edge is accepted
    logic r_armed;

    logic w_par_expected;
    logic w_commit;
    logic w_commit_frm_err;
    logic w_pop;

    // Holding register
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun_err;

    rx_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    // Expected parity bit for the assembled payload
    generate
        if (PARITY_MODE == PAR_ODD) begin : g_par_odd
            assign w_par_expected = ~^r_shreg;
        end else begin : g_par_even
            assign w_par_expected = ^r_shreg;
        end
    endgenerate

    // Arm on an observed high line so enabling mid-character waits for a real start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (!rx_en) begin
            r_armed <= 1'b0;
        end else if (w_rx_s) begin
            r_armed <= 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_cur_par_err <= 1'b0;
            r_cur_frm_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shreg       <= w_shreg_nxt;
            r_cur_par_err <= w_cur_par_err_nxt;
            r_cur_frm_err <= w_cur_frm_err_nxt;
        end
    end

    // Next-state, counters, sampling and commit strobe
    always_comb begin
        w_state_nxt       = r_state;
        w_tick_cnt_nxt    = r_tick_cnt;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_shreg_nxt       = r_shreg;
        w_cur_par_err_nxt = r_cur_par_err;
        w_cur_frm_err_nxt = r_cur_frm_err;
        w_commit          = 1'b0;
        w_commit_frm_err  = r_cur_frm_err;

        if (!rx_en) begin
            // Abort: discard the partial frame, leave the holding register alone
            w_state_nxt    = IDLE;
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
        end else if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s && r_armed) begin
                        w_state_nxt       = START;
                        w_tick_cnt_nxt    = '0;
                        w_bit_cnt_nxt     = '0;
                        w_cur_par_err_nxt = 1'b0;
                        w_cur_frm_err_nxt = 1'b0;
                    end
                end
                START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        w_tick_cnt_nxt = '0;
                        // A high line at mid start bit is a glitch, not a frame
                        w_state_nxt    = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_shreg_nxt    = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_cnt_nxt    = '0;
                        w_cur_par_err_nxt = (w_rx_s != w_par_expected);
                        w_state_nxt       = STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_cnt_nxt    = '0;
                        w_cur_frm_err_nxt = r_cur_frm_err | ~w_rx_s;
                        if (r_bit_cnt == c_STOP_LAST) begin
                            // Commit on the last stop sample; a low line restarts from IDLE
                            w_commit         = 1'b1;
                            w_commit_frm_err = r_cur_frm_err | ~w_rx_s;
                            w_bit_cnt_nxt    = '0;
                            w_state_nxt      = IDLE;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                end
            endcase
        end
    end

    assign w_pop = r_rx_valid & rx_ready;

    // Holding register: load on commit when free or being popped, else flag overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_overrun_err <= 1'b0;
            if (w_commit && (!r_rx_valid || w_pop)) begin
                r_rx_data    <= r_shreg;
                r_parity_err <= r_cur_par_err;
                r_frame_err  <= w_commit_frm_err;
                r_rx_valid   <= 1'b1;
            end else begin
                if (w_commit) begin
                    r_overrun_err <= 1'b1;
                end
                if (w_pop) begin
                    r_rx_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
